memory_bank: RTL and testbench
==============================

MEMORY_BANK -- requirements
Module: memory_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: address width in bits.
REQ-002 SHALL have parameter DATA_W, default 16: word width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W: number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port we, input, 1 bit: write request.
REQ-007 SHALL have port waddr, input, ADDR_W bits: write address.
REQ-008 SHALL have port wdata, input, DATA_W bits: write data.
REQ-009 SHALL have port wbe, input, DATA_W/8 bits: byte enables; bit i covers wdata[8i+7:8i].
REQ-010 SHALL have port re, input, 1 bit: read request.
REQ-011 SHALL have port raddr, input, ADDR_W bits: read address.
REQ-012 SHALL have port rdata, output, DATA_W bits: registered read data.
REQ-013 SHALL have port rvalid, output, 1 bit: rdata valid, one-cycle pulse per read.
REQ-014 SHALL have port busy, output, 1 bit: initialisation sweep in progress.
REQ-015 SHALL have port oob_err, output, 1 bit: out-of-range access pulse.

Function
REQ-016 SHALL implement a two-state FSM: INIT and READY.
REQ-017 In INIT, SHALL write zero to one word per cycle, addresses 0..DEPTH-1 ascending, with busy=1, and enter READY the cycle after address DEPTH-1 is written; the sweep takes exactly DEPTH cycles.
REQ-018 While busy=1, SHALL ignore we and re entirely: no write, rvalid=0, oob_err=0.
REQ-019 In READY, SHALL update only the bytes of mem[waddr] whose wbe bit is 1 when we=1 and waddr<DEPTH; wbe=0 writes nothing.
REQ-020 In READY, re=1 in cycle N SHALL produce rvalid=1 and rdata=mem[raddr] in cycle N+1 (read latency 1).
REQ-021 When rvalid=0, rdata SHALL hold its last value.
REQ-022 When we=1, re=1 and waddr==raddr in the same cycle, SHALL be write-first: rdata equals old word with the enabled bytes replaced by wdata.
REQ-023 An access with address >= DEPTH SHALL not modify memory; a read SHALL return rdata=0 with rvalid=1; oob_err SHALL pulse for one cycle, the cycle after the access.
REQ-024 A write and a read in the same cycle to different valid addresses SHALL both complete with no interaction.

Reset
REQ-025 While rst_n=0 at a clock edge, SHALL set rdata=0, rvalid=0, oob_err=0 and busy=1, and enter INIT with the sweep counter at 0.
REQ-026 Reset asserted mid-sweep or mid-read SHALL restart the sweep from address 0 and drop any pending rvalid.

Configuration
REQ-027 With macro MEMORY_BANK_PARITY_EN defined, SHALL store one even-parity bit per word, recompute it on every write (byte-merged word, including INIT zeroes), and add output perr (1 bit) pulsing with rvalid when the stored parity mismatches the read word; perr resets to 0.
REQ-028 Without MEMORY_BANK_PARITY_EN, SHALL have no parity storage and no perr port.

Structure
REQ-029 SHALL place the FSM state enum (INIT, READY) and the parity function in shared package memory_pkg.
REQ-030 SHALL implement the sweep counter and FSM as sub-module mem_init_seq, outputting busy and the sweep address.

Verification
REQ-031 Reset with DEPTH=256 -> busy=1 for exactly 256 cycles after rst_n rises, then 0; a read of every address returns 0.
REQ-032 Write 16'hABCD to address 5 with wbe=2'b11, then write 16'h1200 with wbe=2'b10 -> re at address 5 gives rdata=16'h12CD one cycle later, rvalid high for 1 cycle.
REQ-033 Same cycle: we=1, re=1, addr 9, wdata 16'h5A5A, wbe=2'b01, old word 16'hFFFF -> rdata=16'hFF5A.
REQ-034 DEPTH=200, write to address 210, then read address 210 -> memory unchanged, rdata=0, oob_err pulses once per access.
REQ-035 rst_n low for one cycle at sweep address 100 -> sweep restarts at 0 and busy lasts DEPTH more cycles.
REQ-036 With MEMORY_BANK_PARITY_EN, force-flip one stored bit of address 3, then read address 3 -> perr=1 together with rvalid; a normal read gives perr=0.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared definitions for memory_bank: init-sequencer FSM states and the word parity helper.
package memory_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  // Widest word the parity helper accepts; callers zero-extend, which leaves parity unchanged.
  localparam int PAR_MAX_W = 1024;

  function automatic logic parity_even(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Power-up/reset sequencer for memory_bank: walks the sweep address 0..DEPTH-1 while busy,
// then parks in READY until the next reset.
module mem_init_seq
  import memory_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  init_state_e       state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      INIT: begin
        if (cnt_reg == LAST_ADDR) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  assign busy       = (state_reg == INIT);
  assign sweep_addr = cnt_reg;

endmodule

// File: rtl/memory_bank.sv
// Byte-enabled simple dual-port RAM with zeroing sweep, write-first reads and range checking.
// Optional per-word even parity with a perr output when MEMORY_BANK_PARITY_EN is defined.
module memory_bank
  import memory_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                busy,
  output logic                oob_err
`ifdef MEMORY_BANK_PARITY_EN
  ,
  output logic                perr
`endif
);

  localparam int              NB        = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] sweep_addr;
  logic              waddr_ok, raddr_ok;
  logic              wr_ok, rd_req, collide, oob_next;

  logic              rd_valid_reg, rd_oob_reg, oob_reg;
  logic [NB-1:0]     rd_byp_reg;
  logic [DATA_W-1:0] wdata_byp_reg, rdata_hold_reg, fresh_word;

  mem_init_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .busy       (busy),
    .sweep_addr (sweep_addr)
  );

  assign waddr_ok = ({1'b0, waddr} < DEPTH_EXT);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_EXT);
  assign wr_ok    = rst_n & ~busy & we & waddr_ok;
  assign rd_req   = rst_n & ~busy & re;
  assign collide  = wr_ok & rd_req & (waddr == raddr);
  assign oob_next = ~busy & ((we & ~waddr_ok) | (re & ~raddr_ok));

`ifdef MEMORY_BANK_PARITY_EN
  logic [DATA_W-1:0] wr_merged, ram_word_q;
`endif

  // One RAM per byte lane; the RAM itself reads old data, the write-first bypass is applied after the output register.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] ram_q;

      always_ff @(posedge clk) begin
        if (busy) begin
          mem_lane[sweep_addr] <= 8'h00;
        end else if (wr_ok && wbe[gi]) begin
          mem_lane[waddr] <= wdata[8*gi +: 8];
        end
        if (rd_req) begin
          ram_q <= mem_lane[raddr];
        end
      end

      assign fresh_word[8*gi +: 8] = rd_byp_reg[gi] ? wdata_byp_reg[8*gi +: 8] : ram_q;
`ifdef MEMORY_BANK_PARITY_EN
      assign wr_merged[8*gi +: 8]  = wbe[gi] ? wdata[8*gi +: 8] : mem_lane[waddr];
      assign ram_word_q[8*gi +: 8] = ram_q;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rd_req) begin
      rd_oob_reg    <= ~raddr_ok;
      rd_byp_reg    <= {NB{collide}} & wbe;
      wdata_byp_reg <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_reg   <= 1'b0;
      oob_reg        <= 1'b0;
      rdata_hold_reg <= '0;
    end else begin
      rd_valid_reg   <= rd_req;
      oob_reg        <= oob_next;
      rdata_hold_reg <= rdata;
    end
  end

  // Between reads the output replays the last delivered word.
  assign rdata   = !rd_valid_reg ? rdata_hold_reg : (rd_oob_reg ? '0 : fresh_word);
  assign rvalid  = rd_valid_reg;
  assign oob_err = oob_reg;

`ifdef MEMORY_BANK_PARITY_EN
  logic par_mem [DEPTH];
  logic par_q;

  always_ff @(posedge clk) begin
    if (busy) begin
      par_mem[sweep_addr] <= 1'b0;
    end else if (wr_ok) begin
      par_mem[waddr] <= parity_even(PAR_MAX_W'(wr_merged));
    end
    if (rd_req) begin
      par_q <= par_mem[raddr];
    end
  end

  // Raw RAM word and stored parity are both pre-write values, so a collision still compares a consistent pair.
  assign perr = rd_valid_reg & ~rd_oob_reg & (par_q != parity_even(PAR_MAX_W'(ram_word_q)));
`endif

endmodule

// File: tb/tb_memory_bank.sv
// Self-checking bench for memory_bank: a DEPTH=256 and a DEPTH=200 instance checked against
// an array model. Parity checks compile in when MEMORY_BANK_PARITY_EN is defined.
module tb_memory_bank;

  logic        clk;
  logic        rst_n   [2];
  logic        we      [2];
  logic        re      [2];
  logic [7:0]  waddr   [2];
  logic [7:0]  raddr   [2];
  logic [15:0] wdata   [2];
  logic [1:0]  wbe     [2];
  logic [15:0] rdata   [2];
  logic        rvalid  [2];
  logic        busy    [2];
  logic        oob_err [2];
`ifdef MEMORY_BANK_PARITY_EN
  logic        perr    [2];
`endif

  int          errors = 0;
  int          checks = 0;
  logic [15:0] model     [2][256];
  logic [15:0] exp_rdata [2];

  memory_bank #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) d0 (
    .clk(clk), .rst_n(rst_n[0]), .we(we[0]), .waddr(waddr[0]), .wdata(wdata[0]), .wbe(wbe[0]),
    .re(re[0]), .raddr(raddr[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .busy(busy[0]),
    .oob_err(oob_err[0])
`ifdef MEMORY_BANK_PARITY_EN
    , .perr(perr[0])
`endif
  );

  memory_bank #(.ADDR_W(8), .DATA_W(16), .DEPTH(200)) d1 (
    .clk(clk), .rst_n(rst_n[1]), .we(we[1]), .waddr(waddr[1]), .wdata(wdata[1]), .wbe(wbe[1]),
    .re(re[1]), .raddr(raddr[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .busy(busy[1]),
    .oob_err(oob_err[1])
`ifdef MEMORY_BANK_PARITY_EN
    , .perr(perr[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic int dep_of(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  function automatic void model_clear(input int d);
    for (int a = 0; a < 256; a++) model[d][a] = 16'h0000;
  endfunction

  function automatic void model_write(input int d, input logic [7:0] wa, input logic [15:0] wd,
                                      input logic [1:0] be);
    if (int'(wa) < dep_of(d)) begin
      for (int b = 0; b < 2; b++)
        if (be[b]) model[d][wa][8*b +: 8] = wd[8*b +: 8];
    end
  endfunction

  function automatic logic [15:0] model_read(input int d, input logic [7:0] ra);
    return (int'(ra) < dep_of(d)) ? model[d][ra] : 16'h0000;
  endfunction

  task automatic access(input int d, input bit w, input logic [7:0] wa, input logic [15:0] wd,
                        input logic [1:0] be, input bit r, input logic [7:0] ra);
    we[d] = w; waddr[d] = wa; wdata[d] = wd; wbe[d] = be; re[d] = r; raddr[d] = ra;
    @(posedge clk); #1;
    we[d] = 1'b0; re[d] = 1'b0;
    $display("[%0t] dut%0d we=%0b wa=%0d wd=%h be=%b re=%0b ra=%0d -> rvalid=%0b rdata=%h oob=%0b",
             $time, d, w, wa, wd, be, r, ra, rvalid[d], rdata[d], oob_err[d]);
  endtask

  // Hammers both ports while sweeping; returns the cycle count until busy drops (-1 if it never does).
  task automatic run_sweep(input bit act0, input bit act1, output int c0, output int c1);
    bit act [2];
    int cnt [2];
    act[0] = act0; act[1] = act1;
    cnt = '{-1, -1};
    for (int cyc = 1; cyc <= 600; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        if (act[d] && cnt[d] < 0) begin
          we[d] = 1'($urandom_range(0, 1)); re[d] = 1'($urandom_range(0, 1));
          waddr[d] = 8'($urandom_range(0, 255)); raddr[d] = 8'($urandom_range(0, 255));
          wdata[d] = 16'($urandom); wbe[d] = 2'b11;
        end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (act[d] && cnt[d] < 0) begin
          we[d] = 1'b0; re[d] = 1'b0;
          checks++;
          if (rvalid[d] !== 1'b0 || oob_err[d] !== 1'b0 || rdata[d] !== exp_rdata[d]) begin
            errors++;
            $display("FAIL sweep_quiet dut%0d cyc=%0d rvalid=%b oob=%b rdata=%h expected 0/0/%h",
                     d, cyc, rvalid[d], oob_err[d], rdata[d], exp_rdata[d]);
          end
          if (busy[d] !== 1'b1) cnt[d] = cyc;
        end
      end
      if ((!act[0] || cnt[0] >= 0) && (!act[1] || cnt[1] >= 0)) break;
    end
    c0 = cnt[0]; c1 = cnt[1];
  endtask

  task automatic test_reset();
    int c0, c1;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; we[d] = 1'b0; re[d] = 1'b0;
      waddr[d] = '0; raddr[d] = '0; wdata[d] = '0; wbe[d] = '0;
      exp_rdata[d] = 16'h0000;
      model_clear(d);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b1 || rvalid[d] !== 1'b0 || oob_err[d] !== 1'b0 || rdata[d] !== 16'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d busy=%b rvalid=%b oob=%b rdata=%h expected 1/0/0/0000",
                 d, busy[d], rvalid[d], oob_err[d], rdata[d]);
      end
`ifdef MEMORY_BANK_PARITY_EN
      checks++;
      if (perr[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_perr dut%0d perr=%b expected 0", d, perr[d]);
      end
`endif
      rst_n[d] = 1'b1;
    end
    run_sweep(1'b1, 1'b1, c0, c1);
    checks++;
    if (c0 != 256) begin
      errors++;
      $display("FAIL sweep_len_256 cycles=%0d expected 256", c0);
    end
    checks++;
    if (c1 != 200) begin
      errors++;
      $display("FAIL sweep_len_200 cycles=%0d expected 200", c1);
    end
  endtask

  task automatic test_read_all();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < dep_of(d); a++) begin
        access(d, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'(a));
        exp_rdata[d] = model_read(d, 8'(a));
        checks++;
        if (rvalid[d] !== 1'b1 || rdata[d] !== exp_rdata[d]) begin
          errors++;
          $display("FAIL read_all dut%0d addr=%0d rvalid=%b rdata=%h expected 1/%h",
                   d, a, rvalid[d], rdata[d], exp_rdata[d]);
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    model_write(0, 8'd5, 16'hABCD, 2'b11);
    access(0, 1'b1, 8'd5, 16'hABCD, 2'b11, 1'b0, 8'd0);
    model_write(0, 8'd5, 16'h1200, 2'b10);
    access(0, 1'b1, 8'd5, 16'h1200, 2'b10, 1'b0, 8'd0);
    checks++;
    if (rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL be_no_rvalid_on_write rvalid=%b expected 0", rvalid[0]);
    end
    access(0, 1'b1, 8'd5, 16'h7777, 2'b00, 1'b0, 8'd0);
    access(0, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd5);
    exp_rdata[0] = 16'h12CD;
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 16'h12CD) begin
      errors++;
      $display("FAIL be_merge rvalid=%b rdata=%h expected 1/12cd", rvalid[0], rdata[0]);
    end
    access(0, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b0, 8'd0);
    checks++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 16'h12CD) begin
      errors++;
      $display("FAIL be_hold rvalid=%b rdata=%h expected 0/12cd", rvalid[0], rdata[0]);
    end
  endtask

  task automatic test_write_first();
    model_write(0, 8'd9, 16'hFFFF, 2'b11);
    access(0, 1'b1, 8'd9, 16'hFFFF, 2'b11, 1'b0, 8'd0);
    model_write(0, 8'd9, 16'h5A5A, 2'b01);
    access(0, 1'b1, 8'd9, 16'h5A5A, 2'b01, 1'b1, 8'd9);
    exp_rdata[0] = 16'hFF5A;
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 16'hFF5A) begin
      errors++;
      $display("FAIL write_first rvalid=%b rdata=%h expected 1/ff5a", rvalid[0], rdata[0]);
    end
    access(0, 1'b1, 8'd20, 16'h0BAD, 2'b11, 1'b1, 8'd9);
    model_write(0, 8'd20, 16'h0BAD, 2'b11);
    checks++;
    if (rdata[0] !== 16'hFF5A) begin
      errors++;
      $display("FAIL write_first_stored rdata=%h expected ff5a", rdata[0]);
    end
  endtask

  task automatic test_oob();
    model_write(1, 8'd199, 16'hBEEF, 2'b11);
    access(1, 1'b1, 8'd199, 16'hBEEF, 2'b11, 1'b1, 8'd199);
    exp_rdata[1] = 16'hBEEF;
    checks++;
    if (oob_err[1] !== 1'b0 || rdata[1] !== 16'hBEEF) begin
      errors++;
      $display("FAIL oob_edge_valid oob=%b rdata=%h expected 0/beef", oob_err[1], rdata[1]);
    end
    access(1, 1'b1, 8'd210, 16'h1111, 2'b11, 1'b0, 8'd0);
    checks++;
    if (oob_err[1] !== 1'b1 || rvalid[1] !== 1'b0 || rdata[1] !== 16'hBEEF) begin
      errors++;
      $display("FAIL oob_write oob=%b rvalid=%b rdata=%h expected 1/0/beef", oob_err[1], rvalid[1], rdata[1]);
    end
    access(1, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b0, 8'd0);
    checks++;
    if (oob_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL oob_pulse_width oob=%b expected 0", oob_err[1]);
    end
    access(1, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd210);
    exp_rdata[1] = 16'h0000;
    checks++;
    if (oob_err[1] !== 1'b1 || rvalid[1] !== 1'b1 || rdata[1] !== 16'h0000) begin
      errors++;
      $display("FAIL oob_read oob=%b rvalid=%b rdata=%h expected 1/1/0000", oob_err[1], rvalid[1], rdata[1]);
    end
    access(1, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b0, 8'd0);
    checks++;
    if (oob_err[1] !== 1'b0 || rvalid[1] !== 1'b0) begin
      errors++;
      $display("FAIL oob_read_pulse oob=%b rvalid=%b expected 0/0", oob_err[1], rvalid[1]);
    end
    access(1, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd200);
    checks++;
    if (oob_err[1] !== 1'b1 || rdata[1] !== 16'h0000) begin
      errors++;
      $display("FAIL oob_first_invalid oob=%b rdata=%h expected 1/0000", oob_err[1], rdata[1]);
    end
    // 210 must not alias onto 10 or 199
    for (int k = 0; k < 2; k++) begin
      logic [7:0] a;
      a = (k == 0) ? 8'd10 : 8'd199;
      access(1, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, a);
      exp_rdata[1] = model_read(1, a);
      checks++;
      if (rdata[1] !== exp_rdata[1] || oob_err[1] !== 1'b0) begin
        errors++;
        $display("FAIL oob_no_side_effect addr=%0d rdata=%h oob=%b expected %h/0", a, rdata[1], oob_err[1], exp_rdata[1]);
      end
    end
  endtask

  task automatic test_random();
    int          d;
    bit          w, r, exp_oob;
    logic [7:0]  wa, ra;
    logic [15:0] wd;
    logic [1:0]  be;
    for (int i = 0; i < 600; i++) begin
      d  = i % 2;
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wa = 8'($urandom_range(0, 255));
      ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 255));
      wd = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      if (w) model_write(d, wa, wd, be);
      if (r) exp_rdata[d] = model_read(d, ra);
      exp_oob = (w && int'(wa) >= dep_of(d)) || (r && int'(ra) >= dep_of(d));
      access(d, w, wa, wd, be, r, ra);
      checks++;
      if (rvalid[d] !== r || rdata[d] !== exp_rdata[d] || oob_err[d] !== exp_oob) begin
        errors++;
        $display("FAIL random dut%0d i=%0d rvalid=%b rdata=%h oob=%b expected %b/%h/%b",
                 d, i, rvalid[d], rdata[d], oob_err[d], r, exp_rdata[d], exp_oob);
      end
`ifdef MEMORY_BANK_PARITY_EN
      checks++;
      if (perr[d] !== 1'b0) begin
        errors++;
        $display("FAIL random_perr dut%0d i=%0d perr=%b expected 0", d, i, perr[d]);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int c0, c1;
    re[0] = 1'b1; raddr[0] = 8'd5; rst_n[0] = 1'b0;
    @(posedge clk); #1;
    re[0] = 1'b0;
    exp_rdata[0] = 16'h0000;
    model_clear(0);
    checks++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 16'h0000 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_read rvalid=%b rdata=%h busy=%b expected 0/0000/1", rvalid[0], rdata[0], busy[0]);
    end
    rst_n[0] = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_sweep_busy busy=%b expected 1", busy[0]);
    end
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    run_sweep(1'b1, 1'b0, c0, c1);
    checks++;
    if (c0 != 256) begin
      errors++;
      $display("FAIL reset_mid_sweep_len cycles=%0d expected 256", c0);
    end
    access(0, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd9);
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_zeroed rvalid=%b rdata=%h expected 1/0000", rvalid[0], rdata[0]);
    end
  endtask

`ifdef MEMORY_BANK_PARITY_EN
  task automatic test_parity();
    access(0, 1'b1, 8'd3, 16'h1234, 2'b11, 1'b0, 8'd0);
    d0.par_mem[3] = ~d0.par_mem[3];
    access(0, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b1, 8'd3);
    checks++;
    if (perr[0] !== 1'b1 || rvalid[0] !== 1'b1) begin
      errors++;
      $display("FAIL parity_detect perr=%b rvalid=%b expected 1/1", perr[0], rvalid[0]);
    end
    access(0, 1'b0, 8'd0, 16'h0000, 2'b00, 1'b0, 8'd0);
    checks++;
    if (perr[0] !== 1'b0) begin
      errors++;
      $display("FAIL parity_pulse perr=%b expected 0", perr[0]);
    end
    access(0, 1'b1, 8'd7, 16'h00F1, 2'b11, 1'b1, 8'd7);
    checks++;
    if (perr[0] !== 1'b0 || rdata[0] !== 16'h00F1) begin
      errors++;
      $display("FAIL parity_clean perr=%b rdata=%h expected 0/00f1", perr[0], rdata[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_all();
    test_byte_enable();
    test_write_first();
    test_oob();
    test_random();
    test_reset_mid();
`ifdef MEMORY_BANK_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
